// File: rtl/draw_pkg.sv
// Shared constants, types and sprite geometry for the sprite redraw arbiter.
package draw_pkg;

    localparam int unsigned SCR_W_DEFAULT = 320;
    localparam int unsigned SCR_H_DEFAULT = 240;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned XW    = 9;
    localparam int unsigned YW    = 8;
    localparam int unsigned CW    = 3;
    localparam int unsigned DIM_W = 4;

    typedef logic [IDX_W-1:0] req_idx_t;

    localparam req_idx_t REQ_PLAYER = 2'd0;
    localparam req_idx_t REQ_ALIEN  = 2'd1;
    localparam req_idx_t REQ_BULLET = 2'd2;

    localparam logic [DIM_W-1:0] PLAYER_W = 4'd8;
    localparam logic [DIM_W-1:0] PLAYER_H = 4'd4;
    localparam logic [DIM_W-1:0] ALIEN_W  = 4'd8;
    localparam logic [DIM_W-1:0] ALIEN_H  = 4'd8;
    localparam logic [DIM_W-1:0] BULLET_W = 4'd1;
    localparam logic [DIM_W-1:0] BULLET_H = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ERASE = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } origin_t;

    function automatic logic [DIM_W-1:0] sprite_w(input req_idx_t idx);
        case (idx)
            REQ_PLAYER: return PLAYER_W;
            REQ_ALIEN:  return ALIEN_W;
            default:    return BULLET_W;
        endcase
    endfunction

    function automatic logic [DIM_W-1:0] sprite_h(input req_idx_t idx);
        case (idx)
            REQ_PLAYER: return PLAYER_H;
            REQ_ALIEN:  return ALIEN_H;
            default:    return BULLET_H;
        endcase
    endfunction

    // Round-robin successor, wrapping the last requester back to the first.
    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == REQ_BULLET) ? REQ_PLAYER : req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/sprite_scanner.sv
// Row-major col/row walker over a width x height box, one position per cycle.
module sprite_scanner
    import draw_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic [DIM_W-1:0] col_o,
    output logic [DIM_W-1:0] row_o,
    output logic             valid_o,
    output logic             last_o
);

    logic             active_q;
    logic             last_q;
    logic [DIM_W-1:0] col_q;
    logic [DIM_W-1:0] row_q;
    logic [DIM_W-1:0] col_d;
    logic [DIM_W-1:0] row_d;
    logic             last_d;

    always_comb begin
        col_d  = col_q + 4'd1;
        row_d  = row_q;
        if (col_q == width_i - 4'd1) begin
            col_d = '0;
            row_d = row_q + 4'd1;
        end
        last_d = (col_d == width_i - 4'd1) && (row_d == height_i - 4'd1);
    end

    // start wins over the final pixel so back-to-back scans leave no gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            last_q   <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            col_q    <= '0;
            row_q    <= '0;
            last_q   <= (width_i == 4'd1) && (height_i == 4'd1);
        end else if (active_q) begin
            if (last_q) begin
                active_q <= 1'b0;
                last_q   <= 1'b0;
            end else begin
                col_q  <= col_d;
                row_q  <= row_d;
                last_q <= last_d;
            end
        end
    end

    assign col_o   = col_q;
    assign row_o   = row_q;
    assign valid_o = active_q;
    assign last_o  = last_q;

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin sprite redraw arbiter: erases each sprite's old box, draws the new
// one, and streams clipped pixel writes to the frame buffer.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int unsigned SCR_W = SCR_W_DEFAULT,
    parameter int unsigned SCR_H = SCR_H_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*XW-1:0] pos_x,
    input  logic [NREQ*YW-1:0] pos_y,
    input  logic [NREQ*CW-1:0] colour_in,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CW-1:0]      colour,
    output logic               plot,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned XP_W = XW + 1;
    localparam int unsigned YP_W = YW + 1;
    localparam logic [XP_W-1:0] X_LIM = XP_W'(SCR_W);
    localparam logic [YP_W-1:0] Y_LIM = YP_W'(SCR_H);

    state_e          state_q;
    logic [NREQ-1:0] pending_q;
    req_idx_t        last_q;
    req_idx_t        gidx_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    origin_t         cur_q;
    logic [CW-1:0]   cur_col_q;
    origin_t         prev_q [NREQ];
    logic [NREQ-1:0] prev_valid_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   colour_q;
    logic            plot_q;
    logic            busy_q;
    logic            overrun_q;

    req_idx_t         pick_c;
    req_idx_t         cand_c;
    logic             found_c;
    req_idx_t         scan_idx_c;
    logic             scan_start_c;
    logic [DIM_W-1:0] scan_col_c;
    logic [DIM_W-1:0] scan_row_c;
    logic             scan_valid_c;
    logic             scan_last_c;
    origin_t          org_c;
    logic [XP_W-1:0]  px_c;
    logic [YP_W-1:0]  py_c;
    logic             in_c;

    // First pending requester after the last granted one.
    always_comb begin
        pick_c  = last_q;
        found_c = 1'b0;
        cand_c  = rr_next(last_q);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!found_c && pending_q[cand_c]) begin
                pick_c  = cand_c;
                found_c = 1'b1;
            end
            cand_c = rr_next(cand_c);
        end
    end

    assign scan_idx_c   = (state_q == ST_ARB) ? pick_c : gidx_q;
    assign scan_start_c = ((state_q == ST_ARB) && found_c) ||
                          ((state_q == ST_ERASE) && scan_last_c);

    sprite_scanner u_scanner (
        .clk      (clk),
        .reset    (reset),
        .start_i  (scan_start_c),
        .width_i  (sprite_w(scan_idx_c)),
        .height_i (sprite_h(scan_idx_c)),
        .col_o    (scan_col_c),
        .row_o    (scan_row_c),
        .valid_o  (scan_valid_c),
        .last_o   (scan_last_c)
    );

    // Pixel address is one bit wider than the port so off-screen sums are caught.
    always_comb begin
        org_c = (state_q == ST_ERASE) ? prev_q[gidx_q] : cur_q;
        px_c  = {1'b0, org_c.x} + XP_W'(scan_col_c);
        py_c  = {1'b0, org_c.y} + YP_W'(scan_row_c);
        in_c  = (px_c < X_LIM) && (py_c < Y_LIM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            last_q       <= REQ_BULLET;
            gidx_q       <= REQ_PLAYER;
            grant_q      <= '0;
            done_q       <= '0;
            cur_q        <= '0;
            cur_col_q    <= '0;
            prev_valid_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < int'(NREQ); i++) begin
                prev_q[i] <= '0;
            end
        end else begin
            done_q <= '0;
            plot_q <= 1'b0;
            if (frame_tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_tick && (req != '0)) begin
                        pending_q <= req;
                        state_q   <= ST_ARB;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (found_c) begin
                        gidx_q    <= pick_c;
                        last_q    <= pick_c;
                        grant_q   <= NREQ'(1) << pick_c;
                        cur_q.x   <= pos_x[XW*pick_c +: XW];
                        cur_q.y   <= pos_y[YW*pick_c +: YW];
                        cur_col_q <= colour_in[CW*pick_c +: CW];
                        state_q   <= prev_valid_q[pick_c] ? ST_ERASE : ST_DRAW;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_ERASE, ST_DRAW: begin
                    x_q      <= px_c[XW-1:0];
                    y_q      <= py_c[YW-1:0];
                    colour_q <= (state_q == ST_ERASE) ? '0 : cur_col_q;
                    plot_q   <= scan_valid_c && in_c;
                    if (scan_last_c) begin
                        if (state_q == ST_ERASE) begin
                            state_q <= ST_DRAW;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= grant_q;
                        end
                    end
                end
                ST_DONE: begin
                    prev_q[gidx_q]       <= cur_q;
                    prev_valid_q[gidx_q] <= 1'b1;
                    pending_q[gidx_q]    <= 1'b0;
                    grant_q              <= '0;
                    if ((pending_q & ~grant_q) != '0) begin
                        state_q <= ST_ARB;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: a reference model queues expected pixels and
// done pulses per frame; a negedge monitor pops and compares them.
module tb_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [2:0]  req;
    logic [26:0] pos_x;
    logic [23:0] pos_y;
    logic [8:0]  colour_in;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    draw_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .req        (req),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .colour_in  (colour_in),
        .grant      (grant),
        .done       (done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t       pix_q[$];
    logic [2:0] done_exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    int         w_tab[3] = '{8, 8, 1};
    int         h_tab[3] = '{4, 8, 3};
    bit         m_prev_v[3];
    int         m_prev_x[3];
    int         m_prev_y[3];
    int         m_last;

    pix_t       mon_pix;
    logic [2:0] mon_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every plot and every done pulse must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (plot === 1'b1) begin
                check("plot_expected", 32'(pix_q.size() > 0), 1);
                if (pix_q.size() > 0) begin
                    mon_pix = pix_q.pop_front();
                    check("pix_x", 32'(x), 32'(mon_pix.px));
                    check("pix_y", 32'(y), 32'(mon_pix.py));
                    check("pix_colour", 32'(colour), 32'(mon_pix.pc));
                end
            end
            if (done !== 3'b000) begin
                check("done_expected", 32'(done_exp_q.size() > 0), 1);
                if (done_exp_q.size() > 0) begin
                    mon_done = done_exp_q.pop_front();
                    check("done_onehot", 32'(done), 32'(mon_done));
                    check("grant_at_done", 32'(grant), 32'(mon_done));
                end
            end
        end
    end

    task automatic set_pos(input int idx, input int px, input int py, input int pc);
        pos_x[9*idx +: 9]     = 9'(px);
        pos_y[8*idx +: 8]     = 8'(py);
        colour_in[3*idx +: 3] = 3'(pc);
    endtask

    task automatic push_sprite(input int ox, input int oy, input int w, input int h, input int pc);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if ((ox + c) < 320 && (oy + r) < 240) begin
                    pix_q.push_back(pix_t'{9'(ox + c), 8'(oy + r), 3'(pc)});
                end
            end
        end
    endtask

    // Reference model of one redraw pass; returns the expected busy length.
    task automatic model_frame(input logic [2:0] r, output int exp_busy);
        logic [2:0] pend;
        int g, ox, oy, oc;
        exp_busy = 0;
        pend = r;
        g = m_last;
        while (pend != 3'b000) begin
            g = (g + 1) % 3;
            if (pend[g]) begin
                ox = int'(pos_x[9*g +: 9]);
                oy = int'(pos_y[8*g +: 8]);
                oc = int'(colour_in[3*g +: 3]);
                exp_busy += 2 + w_tab[g] * h_tab[g];
                if (m_prev_v[g]) begin
                    push_sprite(m_prev_x[g], m_prev_y[g], w_tab[g], h_tab[g], 0);
                    exp_busy += w_tab[g] * h_tab[g];
                end
                push_sprite(ox, oy, w_tab[g], h_tab[g], oc);
                done_exp_q.push_back(3'(1 << g));
                m_prev_v[g] = 1'b1;
                m_prev_x[g] = ox;
                m_prev_y[g] = oy;
                pend[g] = 1'b0;
                m_last = g;
            end
        end
    endtask

    task automatic run_frame(input logic [2:0] r, input int mid_at, input bit scramble);
        int exp_busy, busy_cnt, first_plot;
        req = r;
        model_frame(r, exp_busy);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        busy_cnt = 0;
        first_plot = 0;
        for (int i = 0; i < 2000 && busy === 1'b1; i++) begin
            busy_cnt++;
            if (busy_cnt == 1) check("grant_in_arb", 32'(grant), 0);
            if (plot === 1'b1 && first_plot == 0) first_plot = busy_cnt;
            frame_tick = (busy_cnt == mid_at);
            if (scramble && busy_cnt == 2) begin
                req       = 3'b000;
                pos_x     = 27'($urandom);
                pos_y     = 24'($urandom);
                colour_in = 9'($urandom);
            end
            @(negedge clk);
        end
        frame_tick = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        check("first_plot_cycle", 32'(first_plot), 3);
        check("pix_q_drained", 32'(pix_q.size()), 0);
        check("done_q_drained", 32'(done_exp_q.size()), 0);
        check("grant_idle", 32'(grant), 0);
        check("plot_idle", 32'(plot), 0);
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        req        = 3'b000;
        pos_x      = '0;
        pos_y      = '0;
        colour_in  = '0;
        m_last     = 2;
        for (int i = 0; i < 3; i++) begin
            m_prev_v[i] = 1'b0;
            m_prev_x[i] = 0;
            m_prev_y[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_plot", 32'(plot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        @(negedge clk);

        // Player first frame, then moved with inputs changed after the grant.
        set_pos(0, 100, 200, 2);
        run_frame(3'b001, 0, 1'b0);
        set_pos(0, 101, 200, 2);
        run_frame(3'b001, 0, 1'b1);

        // Three requesters on three successive frames.
        set_pos(0, 10, 10, 5);  set_pos(1, 50, 60, 3);  set_pos(2, 200, 100, 7);
        run_frame(3'b111, 0, 1'b0);
        set_pos(0, 12, 10, 5);  set_pos(1, 52, 62, 3);  set_pos(2, 200, 97, 7);
        run_frame(3'b111, 0, 1'b0);
        set_pos(0, 14, 10, 6);  set_pos(1, 54, 64, 4);  set_pos(2, 200, 94, 1);
        run_frame(3'b111, 0, 1'b0);

        // Alien at the bottom-right corner, mostly clipped.
        set_pos(1, 316, 236, 6);
        run_frame(3'b010, 0, 1'b0);
        check("overrun_clear", 32'(overrun), 0);

        // frame_tick during DRAW: overrun sticks, no extra pass follows.
        set_pos(0, 20, 30, 4);
        run_frame(3'b001, 40, 1'b0);
        check("overrun_set", 32'(overrun), 1);
        repeat (4) @(negedge clk);
        check("no_extra_pass", 32'(busy), 0);

        // Reset during ERASE aborts the scan and forgets previous origins.
        begin
            int exp_busy;
            set_pos(0, 22, 30, 4);
            req = 3'b001;
            model_frame(3'b001, exp_busy);
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            repeat (6) @(negedge clk);
            check("erase_busy", 32'(busy), 1);
            reset = 1'b1;
            #1;
            check("rstmid_plot", 32'(plot), 0);
            check("rstmid_grant", 32'(grant), 0);
            check("rstmid_busy", 32'(busy), 0);
            check("rstmid_overrun", 32'(overrun), 0);
            pix_q.delete();
            done_exp_q.delete();
            for (int i = 0; i < 3; i++) m_prev_v[i] = 1'b0;
            m_last = 2;
            @(negedge clk);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            check("post_rst_idle", 32'(busy), 0);
        end

        // Tick with nothing requested stays idle and sets no overrun.
        req = 3'b000;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("empty_req_idle", 32'(busy), 0);
        check("empty_req_overrun", 32'(overrun), 0);

        // First frame after reset has no erase phase.
        set_pos(0, 30, 40, 1);
        run_frame(3'b001, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
